// File: rtl/iir_pkg.sv
// Shared types and helpers for the cascaded-SOS IIR filter back-ends.
// Holds the default word widths and the round-half-up requantizer.
package iir_pkg;

    localparam int width_H = 15;
    localparam int width_W = 10;

    typedef logic signed [width_H+width_W-1:0] sample_t;

    typedef struct packed {
        logic signed [31:0] value;
        logic               sat;
    } rq_t;

    // The sample arrives sign-extended to 64 bits, so adding the half-LSB
    // bias cannot overflow.
    function automatic rq_t requantize(
        input logic signed [63:0] sample,
        input int                 frac,
        input int                 out_w
    );
        logic signed [64:0] ext;
        logic signed [64:0] one;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        rq_t                r;
        one = 65'sd1;
        ext = {sample[63], sample};
        if (frac > 0) begin
            ext = ext + (one <<< (frac - 1));
        end
        ext = ext >>> frac;
        hi = (one <<< (out_w - 1)) - one;
        lo = -(one <<< (out_w - 1));
        r.value = ext[31:0];
        r.sat = 1'b0;
        if (ext > hi) begin
            r.value = hi[31:0];
            r.sat = 1'b1;
        end else if (ext < lo) begin
            r.value = lo[31:0];
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head entry is always on dout.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo_fwft #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/iir_out_decim.sv
// IIR output stage: decimate, requantize with round-half-up and saturation,
// then buffer into a FWFT FIFO presented as a valid/ready stream.
module iir_out_decim #(
    parameter int width_H    = 15,
    parameter int width_W    = 10,
    parameter int OUT_W      = 12,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_stb,
    input  logic                            s_en,
    input  logic signed [width_H+width_W-1:0] s_data,
    input  logic                            clr_flags,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic signed [OUT_W-1:0]         m_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            sat_flag,
    output logic                            drop_flag
);

    import iir_pkg::*;

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CW-1:0]    cnt;
    logic             accept;
    logic             keep;
    rq_t              rq;
    logic [OUT_W-1:0] q_reg;
    logic             q_valid;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;
    logic [OUT_W-1:0] head;

    assign accept = s_stb & s_en;
    assign keep   = accept && (cnt == '0);
    assign rq     = requantize(64'(s_data), width_W, OUT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_reg   <= '0;
        end else begin
            q_valid <= keep;
            if (keep) begin
                q_reg <= rq.value[OUT_W-1:0];
            end
        end
    end

    assign pop     = m_valid & m_ready;
    assign drop    = q_valid & full & ~pop;
    assign m_valid = ~empty;
    assign m_data  = signed'(head);

    // A set event on the same edge as clr_flags leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (keep && rq.sat) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                drop_flag <= 1'b1;
            end else if (clr_flags) begin
                drop_flag <= 1'b0;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_valid),
        .pop   (pop),
        .din   (q_reg),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule
